// File: rtl/rv32_fetch_stage.sv
// RV32I instruction fetch stage: PC generation, in-order imem requests, and a
// 2-entry IF/ID buffer whose head drives the decode stage from registers.
module rv32_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [24:0] id_imm_field
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] fetch_pc_r;
    logic [1:0]  outstanding_r;
    logic [1:0]  discard_r;
    logic [31:0] pend_pc_r [0:1];
    logic        pend_wr_r;
    logic        pend_rd_r;
    logic [1:0]  occ_r;
    logic        head_valid_r;
    logic [31:0] head_pc_r;
    logic [31:0] head_instr_r;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_instr_r;

    logic        pop_s;
    logic [2:0]  credit_s;
    logic        req_s;
    logic        grant_s;
    logic        resp_s;
    logic        drop_s;
    logic        push_s;
    logic [31:0] resp_pc_s;
    logic [31:0] redirect_target_s;
    logic [1:0]  outstanding_nx_s;
    logic [1:0]  occ_nx_s;
    logic [31:0] head_pc_nx_s;
    logic [31:0] head_instr_nx_s;
    logic [31:0] tail_pc_nx_s;
    logic [31:0] tail_instr_nx_s;

    // Credit counts a same-cycle pop so a full buffer draining can still refill.
    assign pop_s             = head_valid_r && !id_stall;
    assign credit_s          = {1'b0, occ_r} + {1'b0, outstanding_r} - {2'b00, pop_s};
    assign req_s             = !rst && !redirect_valid && (credit_s < 3'd2);
    assign grant_s           = req_s && imem_gnt;
    assign resp_s            = imem_rvalid && (outstanding_r != 2'd0);
    assign drop_s            = resp_s && ((discard_r != 2'd0) || redirect_valid);
    assign push_s            = resp_s && !drop_s;
    assign resp_pc_s         = pend_pc_r[pend_rd_r];
    assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
    assign outstanding_nx_s  = outstanding_r + {1'b0, grant_s} - {1'b0, resp_s};

    assign imem_req     = req_s;
    assign imem_addr    = fetch_pc_r;
    assign id_valid     = head_valid_r;
    assign id_pc        = head_pc_r;
    assign id_instr     = head_instr_r;
    assign id_imm_field = head_instr_r[31:7];

    // IF/ID buffer next state: head register always holds the oldest entry.
    always_comb begin
        occ_nx_s        = occ_r;
        head_pc_nx_s    = head_pc_r;
        head_instr_nx_s = head_instr_r;
        tail_pc_nx_s    = tail_pc_r;
        tail_instr_nx_s = tail_instr_r;
        if (redirect_valid) begin
            occ_nx_s        = 2'd0;
            head_pc_nx_s    = 32'h0000_0000;
            head_instr_nx_s = NOP_INSTR;
        end else begin
            case ({pop_s, push_s})
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        head_pc_nx_s    = tail_pc_r;
                        head_instr_nx_s = tail_instr_r;
                        tail_pc_nx_s    = resp_pc_s;
                        tail_instr_nx_s = imem_rdata;
                    end else begin
                        head_pc_nx_s    = resp_pc_s;
                        head_instr_nx_s = imem_rdata;
                    end
                end
                2'b10: begin
                    if (occ_r == 2'd2) begin
                        head_pc_nx_s    = tail_pc_r;
                        head_instr_nx_s = tail_instr_r;
                        occ_nx_s        = 2'd1;
                    end else begin
                        head_pc_nx_s    = 32'h0000_0000;
                        head_instr_nx_s = NOP_INSTR;
                        occ_nx_s        = 2'd0;
                    end
                end
                2'b01: begin
                    if (occ_r == 2'd0) begin
                        head_pc_nx_s    = resp_pc_s;
                        head_instr_nx_s = imem_rdata;
                        occ_nx_s        = 2'd1;
                    end else begin
                        tail_pc_nx_s    = resp_pc_s;
                        tail_instr_nx_s = imem_rdata;
                        occ_nx_s        = 2'd2;
                    end
                end
                default: begin
                    occ_nx_s = occ_r;
                end
            endcase
        end
    end

    // Fetch PC, in-flight accounting and the pending-PC FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= 2'd0;
            discard_r     <= 2'd0;
            pend_pc_r[0]  <= 32'h0000_0000;
            pend_pc_r[1]  <= 32'h0000_0000;
            pend_wr_r     <= 1'b0;
            pend_rd_r     <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nx_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_target_s;
                discard_r  <= outstanding_nx_s;
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (resp_s && (discard_r != 2'd0)) begin
                    discard_r <= discard_r - 2'd1;
                end
            end
            if (grant_s) begin
                pend_pc_r[pend_wr_r] <= fetch_pc_r;
                pend_wr_r            <= ~pend_wr_r;
            end
            if (resp_s) begin
                pend_rd_r <= ~pend_rd_r;
            end
        end
    end

    // IF/ID buffer registers feeding the decode outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r        <= 2'd0;
            head_valid_r <= 1'b0;
            head_pc_r    <= 32'h0000_0000;
            head_instr_r <= NOP_INSTR;
            tail_pc_r    <= 32'h0000_0000;
            tail_instr_r <= NOP_INSTR;
        end else begin
            occ_r        <= occ_nx_s;
            head_valid_r <= (occ_nx_s != 2'd0);
            head_pc_r    <= head_pc_nx_s;
            head_instr_r <= head_instr_nx_s;
            tail_pc_r    <= tail_pc_nx_s;
            tail_instr_r <= tail_instr_nx_s;
        end
    end

endmodule

// File: doc/rv32_fetch_stage.md
# rv32_fetch_stage

Instruction fetch stage of the 5-stage RV32I pipeline: generates the fetch PC, issues in-order requests to instruction memory, and holds returned instructions in a 2-entry IF/ID buffer. Feeds the decode stage, including the 25-bit `instr[31:7]` field consumed by immediate generation. Takes its redirect target back from the SB/UJ branch/jump target path. Squashes in-flight fetches on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word aligned (`[1:0]` always 0).
- `imem_gnt` in 1: request accepted this cycle when `imem_req && imem_gnt`.
- `imem_rvalid` in 1: response valid. Responses return in order, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: taken branch/jump; flush and refetch.
- `redirect_pc` in 32: new fetch target. Bits `[1:0]` are ignored and treated as 0.
- `id_stall` in 1: decode cannot accept this cycle.
- `id_valid` out 1: IF/ID entry valid.
- `id_instr` out 32: instruction to decode.
- `id_pc` out 32: PC of `id_instr`.
- `id_imm_field` out 25: equals `id_instr[31:7]`.

## Operation
- **State**
  - `fetch_pc`.
  - `outstanding` (0..2): granted requests not yet returned.
  - `discard` (0..2): returning responses to drop.
  - Pending-PC FIFO (2 entries): PCs of granted requests, in order.
  - IF/ID buffer (2 entries): {pc, instr}, `occ` = 0..2.
- **Credit rule:** `imem_req = !rst && !redirect_valid && (occ + outstanding − pop) < 2`, where `pop = id_valid && !id_stall`. The buffer can never overflow.
- **Grant:** `imem_addr = fetch_pc`. On grant, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^32), the PC is pushed to the pending FIFO, and `outstanding` increments.
- **Response:** on `imem_rvalid`, the pending FIFO pops and `outstanding` decrements.
  - If `discard > 0`: the data is dropped and `discard` decrements.
  - Otherwise {pending pc, `imem_rdata`} is pushed to the buffer tail.
- **Output:** head of buffer.
  - `id_valid = (occ != 0)`.
  - When empty, `id_instr = 32'h0000_0013` (NOP) and `id_pc = 0`.
- **Redirect** (highest priority)
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Buffer cleared (`occ <= 0`).
  - `discard <= outstanding` after this cycle's grant/response accounting; a response arriving in the redirect cycle is itself dropped.
  - No request is issued in the redirect cycle.
- **Simultaneous push+pop:** allowed; `occ` unchanged.
- **Pop with `id_stall=1`:** not performed; head held stable.
- **Protocol violation:** `imem_rvalid` with `outstanding == 0` is ignored and leaves state unchanged.
- **Reset**
  - `fetch_pc = RESET_PC`; `outstanding = discard = occ = 0`.
  - `imem_req = 0`, `imem_addr = RESET_PC`, `id_valid = 0`, `id_instr = 32'h0000_0013`, `id_pc = 0`.
  - Reset mid-operation abandons in-flight requests. Memory must also be reset by the same `rst`.

## Timing
- Request granted in cycle N with response in N+k gives `id_valid` for it in N+k+1. Outputs are registered: no combinational path from `imem_rdata` to `id_*`.
- `imem_req` depends combinationally on `id_stall`, `redirect_valid` and registered state only, never on `imem_gnt`.
- **Throughput:** with k=1, continuous grant and `id_stall=0`, one instruction per cycle after a 2-cycle fill.
- **Redirect in cycle R:** first request to the new target in R+1. Its instruction reaches `id_valid` no earlier than R+3 (k=1), regardless of how many stale responses remain.
- `id_*` are stable while `id_valid && id_stall`.

## Test plan
- **Reset/first fetch:** hold `rst` 3 cycles, then release with `imem_gnt=1`, k=1 → `imem_req=1`, `imem_addr=0x0` at cycle 1 after release, then 0x4, 0x8. `id_valid` first rises 2 cycles after the first grant, with `id_pc=0`.
- **Streaming:** memory returns `instr = addr | 0x13` → consecutive `id_pc` 0,4,8,…,0x3C with no bubbles, and `id_imm_field == id_instr[31:7]` every cycle.
- **Stall/backpressure:** assert `id_stall` for 5 cycles during streaming → `id_*` frozen; `imem_req` drops once `occ + outstanding = 2`; no instruction lost or duplicated after release.
- **Redirect with in-flight:** k=3, two outstanding, `redirect_valid` with `redirect_pc=0x0000_0102` → both stale responses dropped; next `imem_addr=0x100`; first post-redirect `id_pc=0x100`.
- **Redirect during stall + simultaneous response:** buffer full, `id_stall=1`, redirect to 0x200 in the same cycle as `imem_rvalid` → `id_valid=0` next cycle; response dropped; fetch resumes at 0x200.
- **Wrap and mid-run reset:** redirect to 0xFFFF_FFFC → next address 0x0000_0000. Assert `rst` with requests outstanding → all outputs at reset values next cycle; refetch from `RESET_PC`.
